// File: rtl/hamming_secded_pipe_if.sv
// hamming_secded_pipe_if: bundles the encode, decode and counter signals of hamming_secded_pipe.
// Widths are derived from DATA_W the same way the core derives them.
`default_nettype none

interface hamming_secded_pipe_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    function automatic int calc_pw(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int P_W    = calc_pw(DATA_W);
    localparam int CODE_W = DATA_W + P_W + 1;

    logic              enc_in_valid;
    logic              enc_in_ready;
    logic [DATA_W-1:0] enc_in_data;
    logic              enc_out_valid;
    logic              enc_out_ready;
    logic [CODE_W-1:0] enc_out_code;
    logic              dec_in_valid;
    logic              dec_in_ready;
    logic [CODE_W-1:0] dec_in_code;
    logic              dec_out_valid;
    logic              dec_out_ready;
    logic [DATA_W-1:0] dec_out_data;
    logic              dec_out_sec;
    logic              dec_out_ded;
    logic [P_W-1:0]    dec_out_syn;
    logic              cnt_clr;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    modport master (
        output enc_in_valid, enc_in_data, enc_out_ready,
        output dec_in_valid, dec_in_code, dec_out_ready, cnt_clr,
        input  enc_in_ready, enc_out_valid, enc_out_code,
        input  dec_in_ready, dec_out_valid, dec_out_data,
        input  dec_out_sec, dec_out_ded, dec_out_syn, sec_cnt, ded_cnt
    );

    modport slave (
        input  enc_in_valid, enc_in_data, enc_out_ready,
        input  dec_in_valid, dec_in_code, dec_out_ready, cnt_clr,
        output enc_in_ready, enc_out_valid, enc_out_code,
        output dec_in_ready, dec_out_valid, dec_out_data,
        output dec_out_sec, dec_out_ded, dec_out_syn, sec_cnt, ded_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: 1-stage SEC-DED encoder and independent 2-stage decoder
// with saturating single/double error counters.
`default_nettype none

module hamming_secded_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    hamming_secded_pipe_if.slave  bus
);
    function automatic int calc_pw(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int             P_W     = calc_pw(DATA_W);
    localparam int             CODE_W  = DATA_W + P_W + 1;
    localparam logic [P_W-1:0] MAX_POS = P_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              par;
        int                j;
        c = '0;
        j = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        // Check positions are still zero here, so including them in the sum is harmless.
        for (int k = 0; k < P_W; k++) begin
            par = 1'b0;
            for (int p = 1; p < CODE_W; p++) begin
                if (((p >> k) & 1) == 1) par = par ^ c[p];
            end
            c[1 << k] = par;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [P_W-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [P_W-1:0] s;
        s = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (c[p]) s = s ^ P_W'(p);
        end
        return s;
    endfunction

    // Encoder
    logic              r_enc_valid;
    logic [CODE_W-1:0] r_enc_code;
    logic              w_enc_ready;

    assign w_enc_ready = !r_enc_valid || bus.enc_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_valid <= 1'b0;
            r_enc_code  <= '0;
        end else if (w_enc_ready) begin
            r_enc_valid <= bus.enc_in_valid;
            if (bus.enc_in_valid) r_enc_code <= encode(bus.enc_in_data);
        end
    end

    assign bus.enc_in_ready  = w_enc_ready;
    assign bus.enc_out_valid = r_enc_valid;
    assign bus.enc_out_code  = r_enc_code;

    // Decoder stage 1: syndrome, overall parity, raw code
    logic              r_s1_valid;
    logic [P_W-1:0]    r_s1_syn;
    logic              r_s1_pe;
    logic [CODE_W-1:0] r_s1_code;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_sec;
    logic              r_s2_ded;
    logic [P_W-1:0]    r_s2_syn;
    logic              w_s1_ready;
    logic              w_s2_ready;

    assign w_s2_ready = !r_s2_valid || bus.dec_out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_syn   <= '0;
            r_s1_pe    <= 1'b0;
            r_s1_code  <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.dec_in_valid;
            if (bus.dec_in_valid) begin
                r_s1_syn  <= syndrome(bus.dec_in_code);
                r_s1_pe   <= ^bus.dec_in_code;
                r_s1_code <= bus.dec_in_code;
            end
        end
    end

    // Classification of the stage-1 contents
    logic [CODE_W-1:0] w_fixed;
    logic              w_sec;
    logic              w_ded;

    always_comb begin
        w_fixed = r_s1_code;
        w_sec   = 1'b0;
        w_ded   = 1'b0;
        if (r_s1_pe) begin
            if (r_s1_syn > MAX_POS) begin
                w_ded = 1'b1;
            end else begin
                w_sec = 1'b1;
                for (int p = 1; p < CODE_W; p++) begin
                    if (r_s1_syn == P_W'(p)) w_fixed[p] = ~r_s1_code[p];
                end
            end
        end else if (r_s1_syn != '0) begin
            w_ded = 1'b1;
        end
    end

    // Decoder stage 2: corrected data and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sec   <= 1'b0;
            r_s2_ded   <= 1'b0;
            r_s2_syn   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= extract(w_fixed);
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
                r_s2_syn  <= r_s1_syn;
            end
        end
    end

    assign bus.dec_in_ready  = w_s1_ready;
    assign bus.dec_out_valid = r_s2_valid;
    assign bus.dec_out_data  = r_s2_data;
    assign bus.dec_out_sec   = r_s2_sec;
    assign bus.dec_out_ded   = r_s2_ded;
    assign bus.dec_out_syn   = r_s2_syn;

    // Error counters
    logic [CNT_W-1:0] r_sec_cnt;
    logic [CNT_W-1:0] r_ded_cnt;
    logic             w_take;

    assign w_take = r_s2_valid && bus.dec_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (w_take) begin
            if (r_s2_sec && r_sec_cnt != CNT_MAX) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (r_s2_ded && r_ded_cnt != CNT_MAX) r_ded_cnt <= r_ded_cnt + 1'b1;
        end
    end

    assign bus.sec_cnt = r_sec_cnt;
    assign bus.ded_cnt = r_ded_cnt;

endmodule

`default_nettype wire

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: payload width, legal range 4..64.
REQ-002 SHALL provide parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL derive, not expose: P_W = smallest r with 2^r >= DATA_W+r+1 (4 for DATA_W=8); CODE_W = DATA_W+P_W+1 (13 for DATA_W=8).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock; all flops update on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enc_in_valid  in  1  encode request valid.
- enc_in_ready  out  1  encoder can accept.
- enc_in_data  in  DATA_W  payload to encode.
- enc_out_valid  out  1  codeword valid.
- enc_out_ready  in  1  downstream accepts codeword.
- enc_out_code  out  CODE_W  SEC-DED codeword.
- dec_in_valid  in  1  decode request valid.
- dec_in_ready  out  1  decoder can accept.
- dec_in_code  in  CODE_W  codeword to check.
- dec_out_valid  out  1  decode result valid.
- dec_out_ready  in  1  downstream accepts result.
- dec_out_data  out  DATA_W  corrected payload.
- dec_out_sec  out  1  single error detected and corrected.
- dec_out_ded  out  1  double error detected, uncorrectable.
- dec_out_syn  out  P_W  Hamming syndrome.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_W  count of accepted SEC results.
- ded_cnt  out  CNT_W  count of accepted DED results.

Function
REQ-005 Code layout SHALL be: bit 0 = overall parity; bit positions 1..CODE_W-1 form a Hamming code with check bits at power-of-two positions; data bits fill the remaining positions in ascending order, data LSB first (DATA_W=8: positions 3,5,6,7,9,10,11,12).
REQ-006 Check bit at position 2^k SHALL equal the even-parity XOR of all positions >0 whose index has bit k set; bit 0 SHALL make the XOR of the whole codeword 0.
REQ-007 Encoder SHALL be one register stage: handshake on enc_in_valid&&enc_in_ready makes enc_out_code valid on the next cycle (latency 1).
REQ-008 enc_in_ready SHALL equal !enc_out_valid || enc_out_ready (combinational; full throughput, one beat per cycle).
REQ-009 While enc_out_valid=1 and enc_out_ready=0, enc_out_code SHALL hold stable.
REQ-010 Decoder SHALL be two register stages: stage 1 registers the syndrome, overall parity and raw code; stage 2 registers the corrected data and flags. Latency SHALL be 2 cycles from accept to dec_out_valid.
REQ-011 Decoder stalls SHALL propagate backward per stage: stage n accepts when empty or when its output is being taken in the same cycle; dec_in_ready SHALL be the stage-1 accept condition; no beat is lost or duplicated.
REQ-012 Syndrome S SHALL be the XOR of the indices of all set bits in positions 1..CODE_W-1; parity error PE SHALL be the XOR of all CODE_W bits.
REQ-013 Classification SHALL be:
- S=0, PE=0: clean; sec=0, ded=0.
- PE=1: single error; if S in 1..CODE_W-1, flip bit S; if S=0, bit 0 is in error and data is unaffected; sec=1.
- S!=0, PE=0: ded=1, sec=0; data passes uncorrected.
- PE=1 with S>CODE_W-1: ded=1, sec=0, no flip.
REQ-014 dec_out_syn SHALL present S unchanged in all cases; sec and ded SHALL never both be 1.
REQ-015 sec_cnt / ded_cnt SHALL each increment by 1 on each dec_out_valid&&dec_out_ready beat carrying the corresponding flag, and SHALL saturate at 2^CNT_W-1.
REQ-016 cnt_clr SHALL zero both counters on the next edge, with priority over a same-cycle increment.
REQ-017 The encoder and decoder paths SHALL be fully independent; simultaneous activity on both SHALL not interact.

Reset
REQ-018 rst=1 SHALL asynchronously force enc_out_valid=0, dec_out_valid=0, all internal stage-valid bits to 0, and sec_cnt=ded_cnt=0; data/code registers SHALL be reset to 0.
REQ-019 Reset mid-operation SHALL discard all in-flight beats; after release, no stale result appears and both ready outputs read 1.

Verification
REQ-020 Encode 0x00 -> enc_out_code=0x0000 one cycle after accept; a decode of it gives data 0x00, sec=0, ded=0, syn=0.
REQ-021 Encode 0xA5, flip code bit 5, decode -> data 0xA5, sec=1, syn=5, sec_cnt 0->1, 2 cycles after accept.
REQ-022 Encode 0xA5, flip code bit 0 only -> data 0xA5, sec=1, syn=0.
REQ-023 Encode 0x3C, flip bits 3 and 6 -> ded=1, sec=0, syn=5, data = raw uncorrected extraction, ded_cnt increments.
REQ-024 Back-to-back 4 decodes with dec_out_ready held 0 for 3 cycles -> dec_in_ready drops once 2 beats are held, results exit in order with no loss; cnt_clr asserted together with a SEC beat -> sec_cnt=0.
REQ-025 Assert rst with 2 decode beats in flight -> dec_out_valid=0 immediately, counters 0, and no result emerges after release.
